aes_block_host: RTL and testbench

// User-side driver for the byte-serial AES core controller. Accepts a 128-bit block+key+mode request,

---
 rtl/aes_block_host.sv | 120 ++++++++++++
 tb/tb_aes_block_host.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_host.sv
// Host-side driver for the byte-serial AES core: latches one request, feeds key/data bytes by the
// core's index, gathers the 16 result bytes in order, parks the core and hands back block + error.
module aes_block_host #(
    parameter int TIMEOUT_CYCLES = 4000,
    parameter int CNT_W          = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_encrypt,
    input  logic [127:0] req_block,
    input  logic [127:0] req_key,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] res_block,
    output logic         res_err,
    output logic         busy,
    output logic         core_start,
    output logic         core_in_encrypt,
    output logic         core_idle,
    output logic [7:0]   core_data_byte,
    output logic [7:0]   core_key_byte,
    input  logic [3:0]   core_out_byte_num,
    input  logic         core_output_valid,
    input  logic [7:0]   core_out_byte
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT, S_STOP, S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0][7:0]  r_block;
    logic [15:0][7:0]  r_key;
    logic [15:0][7:0]  r_res_block;
    logic              r_enc;
    logic              r_res_err;
    logic [3:0]        r_exp_idx;
    logic [CNT_W-1:0]  r_timer;
    logic              w_capture;
    logic              w_err_set;

    // Byte i sits at [127-8i -: 8], which is element 15-i of a [15:0][7:0] view, i.e. ~i.
    assign core_data_byte  = r_block[~core_out_byte_num];
    assign core_key_byte   = r_key[~core_out_byte_num];
    assign core_in_encrypt = r_enc;
    assign req_ready       = (r_state == S_IDLE);
    assign busy            = (r_state != S_IDLE);
    assign core_start      = (r_state == S_START);
    assign core_idle       = (r_state == S_STOP);
    assign res_valid       = (r_state == S_DONE);
    assign res_block       = r_res_block;
    assign res_err         = r_res_err;

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE:  if (req_valid) w_state_nxt = S_START;
            S_START: w_state_nxt = S_WAIT;
            S_WAIT: begin
                // Sequence faults take priority over the timeout in the same cycle.
                if (core_output_valid) begin
                    if (core_out_byte_num == r_exp_idx) begin
                        w_capture = 1'b1;
                        if (r_exp_idx == 4'd15) w_state_nxt = S_STOP;
                    end else begin
                        w_err_set   = 1'b1;
                        w_state_nxt = S_STOP;
                    end
                end else if (r_exp_idx != 4'd0) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = S_STOP;
                end else if (r_timer == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP:  w_state_nxt = S_DONE;
            S_DONE:  if (res_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_block     <= '0;
            r_key       <= '0;
            r_res_block <= '0;
            r_enc       <= 1'b0;
            r_res_err   <= 1'b0;
            r_exp_idx   <= '0;
            r_timer     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && req_valid) begin
                r_block     <= req_block;
                r_key       <= req_key;
                r_enc       <= req_encrypt;
                r_res_block <= '0;
                r_res_err   <= 1'b0;
                r_exp_idx   <= '0;
                r_timer     <= '0;
            end
            if (r_state == S_WAIT && r_timer != '1)
                r_timer <= r_timer + 1'b1;
            if (w_capture) begin
                r_res_block[~r_exp_idx] <= core_out_byte;
                if (r_exp_idx != 4'd15) r_exp_idx <= r_exp_idx + 4'd1;
            end
            if (w_err_set)
                r_res_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aes_block_host.sv
// Bench for aes_block_host: a scripted byte-serial core drives beats; a plain in-order
// reassembly model predicts result block, error flag and where the controller must stop.
module tb_aes_block_host;
    localparam int TO = 64;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0, rst = 1'b1;
    logic         req_valid = 1'b0, req_encrypt = 1'b0, res_ready = 1'b0;
    logic [127:0] req_block = '0, req_key = '0;
    logic [3:0]   core_out_byte_num = '0;
    logic         core_output_valid = 1'b0;
    logic [7:0]   core_out_byte = '0;
    logic         req_ready, res_valid, res_err, busy, core_start, core_in_encrypt, core_idle;
    logic [127:0] res_block;
    logic [7:0]   core_data_byte, core_key_byte;

    always #5 clk = ~clk;

    aes_block_host #(.TIMEOUT_CYCLES(TO), .CNT_W(12)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_encrypt(req_encrypt), .req_block(req_block), .req_key(req_key),
        .res_valid(res_valid), .res_ready(res_ready), .res_block(res_block), .res_err(res_err),
        .busy(busy), .core_start(core_start), .core_in_encrypt(core_in_encrypt),
        .core_idle(core_idle), .core_data_byte(core_data_byte), .core_key_byte(core_key_byte),
        .core_out_byte_num(core_out_byte_num), .core_output_valid(core_output_valid),
        .core_out_byte(core_out_byte)
    );

    int n_chk = 0, n_err = 0, n_start = 0, n_idle = 0;
    always @(posedge clk) begin
        if (core_start) n_start <= n_start + 1;
        if (core_idle)  n_idle  <= n_idle + 1;
    end

    // Core beat script: one entry per WAIT cycle.
    logic       bv [0:39];
    logic [3:0] bn [0:39];
    logic [7:0] bb [0:39];
    int         nb;
    logic [127:0] last_blk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [127:0] v, input int i);
        return v[127-8*i -: 8];
    endfunction

    // lead idle cycles, then 16 in-order valid bytes of data
    task automatic load_seq(input logic [127:0] data, input int lead);
        nb = lead + 16;
        for (int k = 0; k < lead; k++) begin
            bv[k] = 1'b0; bn[k] = 4'($urandom_range(0, 15)); bb[k] = 8'($urandom);
        end
        for (int k = 0; k < 16; k++) begin
            bv[lead+k] = 1'b1; bn[lead+k] = 4'(k); bb[lead+k] = byte_of(data, k);
        end
    endtask

    // Reference: reassemble bytes in index order; stop on completion, wrong index or gap.
    task automatic model(output logic [127:0] eb, output logic ee, output int stop_at);
        int idx;
        eb = '0; ee = 1'b0; idx = 0; stop_at = -1;
        for (int k = 0; k < nb && stop_at < 0; k++) begin
            if (bv[k]) begin
                if (int'(bn[k]) == idx) begin
                    eb[127-8*idx -: 8] = bb[k];
                    idx++;
                    if (idx == 16) stop_at = k;
                end else begin
                    ee = 1'b1; stop_at = k;
                end
            end else if (idx > 0) begin
                ee = 1'b1; stop_at = k;
            end
        end
    endtask

    task automatic accept(input logic enc, input logic [127:0] blk, input logic [127:0] key);
        @(negedge clk);
        chk("req_ready_before", req_ready, 1);
        req_valid = 1'b1; req_encrypt = enc; req_block = blk; req_key = key;
        @(negedge clk);
        req_valid = 1'b0; req_encrypt = ~enc; req_block = {4{$urandom}}; req_key = {4{$urandom}};
        chk("start_pulse", core_start, 1);
        chk("start_mode", core_in_encrypt, enc);
        chk("busy_start", busy, 1);
    endtask

    task automatic run_txn(input logic enc, input logic [127:0] blk, input logic [127:0] key,
                           input bit hold, input int abort_after);
        logic [127:0] eb;
        logic ee;
        int stop_at, last, s0, i0;
        s0 = n_start; i0 = n_idle;
        model(eb, ee, stop_at);
        accept(enc, blk, key);
        @(negedge clk);
        last = (abort_after >= 0) ? abort_after : stop_at + 1;
        for (int k = 0; k < last; k++) begin
            core_output_valid = bv[k]; core_out_byte_num = bn[k]; core_out_byte = bb[k];
            #1;
            chk("data_mux", core_data_byte, byte_of(blk, int'(bn[k])));
            chk("key_mux", core_key_byte, byte_of(key, int'(bn[k])));
            @(negedge clk);
        end
        core_output_valid = 1'b0;
        if (abort_after >= 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("rst_req_ready", req_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_res_block", res_block, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_no_idle", n_idle - i0, 0);
            return;
        end
        chk("stop_idle_pulse", core_idle, 1);
        chk("stop_res_valid", res_valid, 0);
        @(negedge clk);
        chk("done_res_valid", res_valid, 1);
        chk("done_idle_low", core_idle, 0);
        chk("done_block", res_block, eb);
        chk("done_err", res_err, ee);
        chk("idle_count", n_idle - i0, 1);
        last_blk = res_block;
        if (hold) begin
            for (int c = 0; c < 20; c++) begin
                req_valid = 1'b1; req_block = {4{$urandom}};
                @(negedge clk);
                chk("hold_valid", res_valid, 1);
                chk("hold_block", res_block, eb);
                chk("hold_err", res_err, ee);
                chk("hold_req_ready", req_ready, 0);
            end
            req_valid = 1'b0;
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("post_req_ready", req_ready, 1);
        chk("post_res_valid", res_valid, 0);
        chk("post_busy", busy, 0);
        chk("start_count", n_start - s0, 1);
    endtask

    initial begin
        int cyc, s0;
        logic [127:0] rb, rk, rd;
        repeat (2) @(negedge clk);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_res_valid", res_valid, 0);
        chk("reset_res_err", res_err, 0);
        chk("reset_start", core_start, 0);
        chk("reset_idle", core_idle, 0);
        chk("reset_block", res_block, 0);
        rst = 1'b0;

        // known-answer encrypt, then decrypt with a long result stall
        load_seq(CT, 0);
        run_txn(1'b1, PT, KEY, 1'b0, -1);
        chk("kat_encrypt", last_blk, CT);
        load_seq(PT, 2);
        run_txn(1'b0, CT, KEY, 1'b1, -1);
        chk("kat_decrypt", last_blk, PT);

        // core never answers: abort after TO cycles in WAIT
        s0 = n_start;
        accept(1'b1, PT, KEY);
        cyc = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (core_idle) begin cyc = c; break; end
        end
        chk("timeout_idle_cycle", cyc, TO + 1);
        @(negedge clk);
        chk("timeout_res_valid", res_valid, 1);
        chk("timeout_err", res_err, 1);
        chk("timeout_block", res_block, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("timeout_back_idle", req_ready, 1);
        chk("timeout_one_start", n_start - s0, 1);

        // wrong index: 0,1,3
        rd = {4{$urandom}};
        load_seq(rd, 0);
        bn[2] = 4'd3; bb[2] = 8'($urandom);
        run_txn(1'b1, {4{$urandom}}, {4{$urandom}}, 1'b0, -1);
        // gap after byte 5
        rd = {4{$urandom}};
        load_seq(rd, 1);
        bv[7] = 1'b0;
        run_txn(1'b0, {4{$urandom}}, {4{$urandom}}, 1'b0, -1);

        // reset mid-WAIT after 7 bytes, then a clean request
        load_seq({4{$urandom}}, 0);
        run_txn(1'b1, {4{$urandom}}, {4{$urandom}}, 1'b0, 7);
        rd = {4{$urandom}};
        load_seq(rd, 0);
        run_txn(1'b0, {4{$urandom}}, {4{$urandom}}, 1'b0, -1);
        chk("post_reset_block", last_blk, rd);

        // randomized clean transactions with random start latency
        for (int t = 0; t < 6; t++) begin
            rb = {4{$urandom}}; rk = {4{$urandom}}; rd = {4{$urandom}};
            load_seq(rd, int'($urandom_range(0, 3)));
            run_txn(1'($urandom), rb, rk, 1'b0, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
